wptr_sync_r2: RTL and testbench

Read-domain write-pointer synchronizer and level tracker for the asynchronous FIFO. It takes the Gray-coded write pointer from the write clock domain and passes it through a multi-flop synchronizer clocked by clk_r. It then converts the result to binary and drives `wptr_bin_sync` into the read-pointer/empty stage. It also produces the read-side fill level and an almost-empty flag from the synchronized write pointer and the read stage's binary `rptr`.

---
 rtl/wptr_sync_r2.sv | 130 +++++++++++++
 tb/tb_wptr_sync_r2.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_sync_r2.sv
// wptr_sync_r2
// Read-domain write-pointer synchronizer and level tracker for the async FIFO.
// Carries the Gray write pointer into clk_r through a flop chain, converts the
// synchronized value to binary and derives the read-side fill level and an
// almost-empty flag against the read stage's binary pointer.
//
// Parameters:
//   depth        FIFO depth (power of two, >= 4); pointers are AW+1 bits
//   sync_stages  number of synchronizer flops (2..4)
//   ae_thresh    almost-empty threshold in words (0..depth)
//
// Ports:
//   clk_r           in   read clock
//   rst_r           in   asynchronous active-low reset
//   wptr_gray_w     in   Gray write pointer, registered in the write domain
//   rptr            in   binary read pointer from the read-pointer/empty stage
//   wptr_bin_sync   out  synchronized binary write pointer (registered)
//   wptr_gray_sync  out  last synchronizer stage, Gray (registered)
//   rd_level        out  words available to read, 0..depth
//   almost_empty    out  rd_level <= ae_thresh
//   sync_err        out  sticky integrity error
//
// Optional feature: define WPTR_SYNC_CHECK_EN to enable the integrity checker
// (multi-bit Gray step or impossible fill level). Without it sync_err is 0.
module wptr_sync_r2 #(
  parameter int depth       = 1024,
  parameter int sync_stages = 2,
  parameter int ae_thresh   = 4,
  localparam int AW         = $clog2(depth)
) (
  input  logic        clk_r,
  input  logic        rst_r,
  input  logic [AW:0] wptr_gray_w,
  input  logic [AW:0] rptr,
  output logic [AW:0] wptr_bin_sync,
  output logic [AW:0] wptr_gray_sync,
  output logic [AW:0] rd_level,
  output logic        almost_empty,
  output logic        sync_err
);

  // depth and ae_thresh both fit in AW+1 bits since ae_thresh <= depth = 2^AW
  localparam logic [AW:0] DEPTH_V = (AW+1)'(depth);
  localparam logic [AW:0] AE_V    = (AW+1)'(ae_thresh);

  // ---------------------------------------------------------------------------
  // Synchronizer chain: only the Gray value crosses into clk_r
  // ---------------------------------------------------------------------------
  logic [AW:0] s_reg [sync_stages];

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      s_reg[0] <= '0;
    end else begin
      s_reg[0] <= wptr_gray_w;
    end
  end

  generate
    for (genvar gi = 1; gi < sync_stages; gi++) begin : g_sync
      always_ff @(posedge clk_r or negedge rst_r) begin
        if (!rst_r) begin
          s_reg[gi] <= '0;
        end else begin
          s_reg[gi] <= s_reg[gi-1];
        end
      end
    end
  endgenerate

  assign wptr_gray_sync = s_reg[sync_stages-1];

  // ---------------------------------------------------------------------------
  // Gray to binary: b[i] is the XOR of all Gray bits from the MSB down to i.
  // Written as a reduction per bit so there is no bit-to-bit chain on one net.
  // ---------------------------------------------------------------------------
  logic [AW:0] bin_next;

  generate
    for (genvar gi = 0; gi <= AW; gi++) begin : g_g2b
      assign bin_next[gi] = ^wptr_gray_sync[AW:gi];
    end
  endgenerate

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      wptr_bin_sync <= '0;
    end else begin
      wptr_bin_sync <= bin_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Level and almost-empty: modulo 2^(AW+1) subtraction handles pointer wrap;
  // differing MSBs with equal low bits naturally yields depth.
  // ---------------------------------------------------------------------------
  assign rd_level     = wptr_bin_sync - rptr;
  assign almost_empty = (rd_level <= AE_V);

  // ---------------------------------------------------------------------------
  // Optional integrity checker
  // ---------------------------------------------------------------------------
`ifdef WPTR_SYNC_CHECK_EN
  logic [AW:0] g_prev_reg;
  logic        armed_reg;     // g_prev_reg holds a sampled value, not reset
  logic        sync_err_reg;
  logic        multi_bit;
  logic        level_bad;

  assign multi_bit = armed_reg && ($countones(wptr_gray_sync ^ g_prev_reg) > 1);
  assign level_bad = (rd_level > DEPTH_V);

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      g_prev_reg   <= '0;
      armed_reg    <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      g_prev_reg   <= wptr_gray_sync;
      armed_reg    <= 1'b1;
      sync_err_reg <= sync_err_reg | multi_bit | level_bad;
    end
  end

  assign sync_err = sync_err_reg;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_sync_r2.sv
// Directed testbench for wptr_sync_r2 with default parameters.
module tb_wptr_sync_r2;

  localparam int AW = 10;

`ifdef WPTR_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk_r;
  logic          rst_r;
  logic [AW:0]   wptr_gray_w;
  logic [AW:0]   rptr;
  logic [AW:0]   wptr_bin_sync;
  logic [AW:0]   wptr_gray_sync;
  logic [AW:0]   rd_level;
  logic          almost_empty;
  logic          sync_err;

  int checks = 0;
  int errors = 0;
  int wbin   = 0;

  wptr_sync_r2 #(.depth(1024), .sync_stages(2), .ae_thresh(4)) dut (
    .clk_r          (clk_r),
    .rst_r          (rst_r),
    .wptr_gray_w    (wptr_gray_w),
    .rptr           (rptr),
    .wptr_bin_sync  (wptr_bin_sync),
    .wptr_gray_sync (wptr_gray_sync),
    .rd_level       (rd_level),
    .almost_empty   (almost_empty),
    .sync_err       (sync_err)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  // advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  task automatic do_reset(input logic [AW:0] g);
    rst_r = 1'b0;
    wptr_gray_w = g;
    rptr = '0;
    tick();
    tick();
    rst_r = 1'b1;
    wbin = 0;
  endtask

  // walk the write pointer one step at a time, then let it settle
  task automatic step_to(input int n);
    while (wbin < n) begin
      wbin++;
      wptr_gray_w = gray(wbin);
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_r = 1'b0;
    wptr_gray_w = 11'h005;
    rptr = '0;
    tick();
    tick();
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sync_err); end
    rst_r = 1'b1;
    tick();
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL rel_edge1_bin: got %0d expected 0", wptr_bin_sync); end
    tick();
    checks++; if (wptr_gray_sync !== 11'h005) begin errors++; $display("FAIL rel_edge2_gray: got %0h expected 5", wptr_gray_sync); end
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL rel_edge2_bin: got %0d expected 0", wptr_bin_sync); end
    tick();
    checks++; if (wptr_bin_sync !== 11'd6) begin errors++; $display("FAIL rel_edge3_bin: got %0d expected 6", wptr_bin_sync); end
    $display("test_reset done: bin=%0d level=%0d", wptr_bin_sync, rd_level);
  endtask

  task automatic test_latency();
    do_reset(11'h000);
    repeat (3) tick();
    wptr_gray_w = 11'h001;
    tick();
    checks++; if (wptr_gray_sync !== 11'd0) begin errors++; $display("FAIL lat_edge1_gray: got %0d expected 0", wptr_gray_sync); end
    tick();
    checks++; if (wptr_gray_sync !== 11'd1) begin errors++; $display("FAIL lat_edge2_gray: got %0d expected 1", wptr_gray_sync); end
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL lat_edge2_bin: got %0d expected 0", wptr_bin_sync); end
    tick();
    checks++; if (wptr_bin_sync !== 11'd1) begin errors++; $display("FAIL lat_edge3_bin: got %0d expected 1", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd1) begin errors++; $display("FAIL lat_level: got %0d expected 1", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL lat_ae: got %b expected 1", almost_empty); end
    $display("test_latency done: gray=%0d bin=%0d", wptr_gray_sync, wptr_bin_sync);
  endtask

  task automatic test_threshold();
    do_reset(11'h000);
    step_to(4);
    checks++; if (rd_level !== 11'd4) begin errors++; $display("FAIL thr_level4: got %0d expected 4", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae4: got %b expected 1", almost_empty); end
    step_to(5);
    checks++; if (rd_level !== 11'd5) begin errors++; $display("FAIL thr_level5: got %0d expected 5", rd_level); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL thr_ae5: got %b expected 0", almost_empty); end
    rptr = 11'd1;
    #1;
    checks++; if (rd_level !== 11'd4) begin errors++; $display("FAIL thr_rptr_level: got %0d expected 4", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_rptr_ae: got %b expected 1", almost_empty); end
    $display("test_threshold done: level=%0d ae=%b", rd_level, almost_empty);
  endtask

  // continues from test_threshold: wptr 5, rptr 1
  task automatic test_simultaneous();
    wptr_gray_w = gray(6);
    tick();
    tick();
    checks++; if (wptr_bin_sync !== 11'd5) begin errors++; $display("FAIL sim_pre_bin: got %0d expected 5", wptr_bin_sync); end
    tick();
    rptr = 11'd2;  // same cycle in which wptr_bin_sync moves to 6
    #1;
    checks++; if (wptr_bin_sync !== 11'd6) begin errors++; $display("FAIL sim_bin: got %0d expected 6", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd4) begin errors++; $display("FAIL sim_level: got %0d expected 4", rd_level); end
    $display("test_simultaneous done: level=%0d", rd_level);
  endtask

  task automatic test_wrap();
    do_reset(11'h000);
    repeat (3) tick();
    rptr = 11'd1024;
    #1;
    checks++; if (rd_level !== 11'd1024) begin errors++; $display("FAIL wrap_init_level: got %0d expected 1024", rd_level); end
    wptr_gray_w = 11'h400;
    repeat (3) tick();
    checks++; if (wptr_bin_sync !== 11'd2047) begin errors++; $display("FAIL wrap_bin2047: got %0d expected 2047", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd1023) begin errors++; $display("FAIL wrap_level1023: got %0d expected 1023", rd_level); end
    wptr_gray_w = 11'h000;
    repeat (3) tick();
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL wrap_bin0: got %0d expected 0", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd1024) begin errors++; $display("FAIL wrap_level1024: got %0d expected 1024", rd_level); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL wrap_ae: got %b expected 0", almost_empty); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", sync_err); end
    $display("test_wrap done: bin=%0d level=%0d", wptr_bin_sync, rd_level);
  endtask

  task automatic test_integrity();
    do_reset(11'h000);
    repeat (4) tick();
    wptr_gray_w = 11'h003;
    tick();
    tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL int_before: got %b expected 0", sync_err); end
    tick();
    checks++; if (sync_err !== CHK) begin errors++; $display("FAIL int_set: got %b expected %b", sync_err, CHK); end
    wptr_gray_w = 11'h002;
    repeat (4) tick();
    checks++; if (sync_err !== CHK) begin errors++; $display("FAIL int_hold: got %b expected %b", sync_err, CHK); end
    #2;
    rst_r = 1'b0;
    #1;
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL int_clear: got %b expected 0", sync_err); end
    tick();
    rst_r = 1'b1;
    $display("test_integrity done: check_en=%b", CHK);
  endtask

  task automatic test_reset_midstream();
    do_reset(11'h000);
    for (int i = 0; i < 8; i++) begin
      wbin++;
      wptr_gray_w = gray(wbin);
      tick();
    end
    checks++; if (wptr_bin_sync !== 11'd6) begin errors++; $display("FAIL mid_run_bin: got %0d expected 6", wptr_bin_sync); end
    #2;
    rst_r = 1'b0;  // asserted between edges
    #1;
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL mid_rst_bin: got %0d expected 0", wptr_bin_sync); end
    checks++; if (wptr_gray_sync !== 11'd0) begin errors++; $display("FAIL mid_rst_gray: got %0d expected 0", wptr_gray_sync); end
    checks++; if (rd_level !== 11'd0) begin errors++; $display("FAIL mid_rst_level: got %0d expected 0", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_ae: got %b expected 1", almost_empty); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", sync_err); end
    for (int i = 0; i < 2; i++) begin
      wbin++;
      wptr_gray_w = gray(wbin);
      tick();
    end
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL mid_held_bin: got %0d expected 0", wptr_bin_sync); end
    wptr_gray_w = gray(20);
    rst_r = 1'b1;
    tick();
    tick();
    checks++; if (wptr_bin_sync !== 11'd0) begin errors++; $display("FAIL mid_rel2_bin: got %0d expected 0", wptr_bin_sync); end
    checks++; if (wptr_gray_sync !== 11'd30) begin errors++; $display("FAIL mid_rel2_gray: got %0d expected 30", wptr_gray_sync); end
    tick();
    checks++; if (wptr_bin_sync !== 11'd20) begin errors++; $display("FAIL mid_rel3_bin: got %0d expected 20", wptr_bin_sync); end
    checks++; if (rd_level !== 11'd20) begin errors++; $display("FAIL mid_rel3_level: got %0d expected 20", rd_level); end
    $display("test_reset_midstream done: bin=%0d", wptr_bin_sync);
  endtask

  initial begin
    rst_r = 1'b0;
    wptr_gray_w = '0;
    rptr = '0;
    test_reset();
    test_latency();
    test_threshold();
    test_simultaneous();
    test_wrap();
    test_integrity();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
